gmii_tx_checker: RTL and testbench
==================================

# gmii_tx_checker

Passive byte-wide monitor on the GMII transmit output of the Ethernet packet engine, sitting directly downstream of `txd`/`tx_en`. It parses each frame's preamble and SFD, runs CRC-32 over the payload and FCS, and checks frame length and inter-frame gap. For every frame it reports length and an error code, and it keeps saturating good/bad counters. It never drives the link. It serves as a self-check in simulation and as a hardware health counter behind the local bus.

## Interface
- `MIN_LEN`, 64: minimum legal length; bytes after SFD, FCS included.
- `MAX_LEN`, 1518: maximum legal length, same byte counting.
- `MIN_IFG`, 12: minimum number of idle cycles between frames.
- `PRE_LEN`, 7: exact count of 0x55 bytes required before SFD 0xD5.

Ports:
- `clk` in 1: GMII tx clock, 125 MHz. This is the block's single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `txd` in 8: transmit data, sampled on the rising edge of `clk`.
- `tx_en` in 1: transmit enable.
- `clr` in 1: synchronous clear of both counters.
- `frame_stb` out 1: one-cycle strobe; the status outputs are valid while it is high.
- `frame_len` out 16: byte count after SFD; saturates at 0xFFFF.
- `frame_err` out 6: error bits.
  - [0] CRC error.
  - [1] preamble/SFD error.
  - [2] runt.
  - [3] giant.
  - [4] IFG violation.
  - [5] abort (`tx_en` dropped before SFD).
- `good_cnt` out 16: frames with `frame_err==0`; saturating.
- `bad_cnt` out 16: frames with nonzero `frame_err`; saturating.
- `busy` out 1: high in any state except IDLE and GAP.

## Operation
The state machine has four states: IDLE, PRE, BODY, GAP.

IDLE:
- On `tx_en=1`, go to PRE.
- Clear the preamble counter and all error accumulators.
- Latch the IFG flag if the gap counter is below `MIN_IFG`. The gap counter is not checked before the first frame after reset.

PRE:
- A 0x55 byte increments the preamble counter.
- A 0xD5 byte goes to BODY. Set bit 1 if the preamble count is not equal to `PRE_LEN`.
- Any other byte sets bit 1 and the block stays in PRE, waiting for 0xD5.
- `tx_en=0` goes to GAP. Report with bit 5 set and `frame_len=0`.

BODY:
- Each byte updates the CRC and increments the length.
- CRC rule: reflected CRC-32, polynomial 0xEDB88320, initial value 0xFFFFFFFF, applied LSB-first over every byte after SFD, FCS included.
- The frame's CRC is good iff the register equals 0xDEBB20E3 after the last byte.
- `tx_en=0` goes to GAP and reports the frame:
  - Bit 0 is set if the CRC is bad.
  - Bit 2 is set if `frame_len < MIN_LEN`.
  - Bit 3 is set if `frame_len > MAX_LEN`.
  - Bit 4 is the latched IFG flag.

GAP:
- The gap counter counts idle cycles and saturates at 255.
- `tx_en=1` behaves exactly like `tx_en=1` in IDLE.
- When the gap counter reaches `MIN_IFG`, go to IDLE.

Counters:
- On `frame_stb`, increment `good_cnt` or `bad_cnt`, saturating at 0xFFFF.
- `clr` zeroes both counters and takes priority over a simultaneous increment.

`rx_er`-style errors are not monitored; there is no such input.

## Timing
- Reset values: all outputs are 0 and the state is IDLE. The gap counter resets to 255, so the first frame never raises an IFG flag.
- Let edge N be the first edge that samples `tx_en=0` after a frame. `frame_stb`, `frame_len` and `frame_err` are registered and update at edge N, so they are visible in the following cycle. `frame_stb` is high for exactly one cycle.
- The counters update at edge N+1.
- `frame_len` and `frame_err` hold their values until the next `frame_stb`.
- Back-to-back frames are distinguished by a single low cycle of `tx_en`. That case produces a strobe and sets the IFG bit on the next frame.
- If `rst_n` is asserted mid-frame, no strobe is emitted and the counters clear. After deassertion, monitoring resumes with the first rising edge of `tx_en`.
- Throughput: one byte per cycle, with no backpressure.

## Structure
- Shared package `gmii_pkg` holds:
  - the state encoding;
  - the error bit positions;
  - `CRC_POLY_R = 32'hEDB88320`;
  - `CRC_RESIDUE = 32'hDEBB20E3`;
  - `SFD = 8'hD5` and `PRE_BYTE = 8'h55`.
- Sub-module `crc32_byte` is combinational: next = f(crc, byte), unrolled over 8 bits. It is reusable by an rx-side checker.
- The FSM and counters stay in the top level.

## Test plan
- Good 64-byte frame:
  - Stimulus: 7×0x55, 0xD5, 60 bytes 0x00, then the bench-computed FCS (LSB-first), followed by 12 idle cycles.
  - Response: `frame_len=64`, `frame_err=0`, `good_cnt=1`.
- Standard check value:
  - Stimulus: ASCII "123456789" followed by FCS bytes 26 39 F4 CB.
  - Response: `frame_len=13`, `frame_err=0x04` (runt only, CRC good), `bad_cnt=1`.
- Corrupted frame:
  - Stimulus: the good 64-byte frame with one payload bit flipped.
  - Response: `frame_err=0x01`.
- Short preamble, then a too-close frame:
  - Stimulus: 6×0x55, then a good frame with 5 idle cycles before the next good frame.
  - Response: first report `frame_err=0x02`; second report `frame_err=0x10`.
- Abort and clear:
  - Stimulus: `tx_en` drops after 3×0x55.
  - Response: `frame_err=0x20`, `frame_len=0`.
  - Then pulse `clr` in the same cycle as a counter increment: both counters read 0.
- Reset mid-frame:
  - Stimulus: assert `rst_n=0` in the middle of BODY.
  - Response: no strobe, counters 0; the next good frame is reported with `frame_err=0`.

Source files
------------

// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII transmit checker: FSM encoding, error bit
// positions, CRC-32 constants and preamble/SFD byte values.
package gmii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_BODY = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam int ERR_CRC   = 0;
  localparam int ERR_PRE   = 1;
  localparam int ERR_RUNT  = 2;
  localparam int ERR_GIANT = 3;
  localparam int ERR_IFG   = 4;
  localparam int ERR_ABORT = 5;
  localparam int ERR_W     = 6;

  localparam logic [31:0] CRC_POLY_R  = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;

  localparam logic [7:0] SFD      = 8'hD5;
  localparam logic [7:0] PRE_BYTE = 8'h55;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational reflected CRC-32 update over one byte, LSB first.
// Shared between the tx and rx checkers.
module crc32_byte
  import gmii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  // NOTE: blocking assignments here are deliberate; each loop iteration
  // consumes the value produced by the previous one within the same pass.
  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/gmii_tx_checker.sv
// Passive GMII transmit monitor: preamble/SFD parse, CRC-32, length and IFG
// checks, per-frame status strobe and saturating good/bad frame counters.
module gmii_tx_checker
  import gmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int MIN_IFG = 12,
  parameter int PRE_LEN = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  txd,
  input  logic        tx_en,
  input  logic        clr,
  output logic        frame_stb,
  output logic [15:0] frame_len,
  output logic [5:0]  frame_err,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt,
  output logic        busy
);

  localparam logic [15:0] MIN_LEN_C = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);
  localparam logic [7:0]  MIN_IFG_C = 8'(MIN_IFG);
  localparam logic [7:0]  PRE_LEN_C = 8'(PRE_LEN);

  state_e             state_q, state_d;
  logic [7:0]         pre_cnt_q, pre_cnt_d;
  logic [7:0]         gap_cnt_q, gap_cnt_d;
  logic [31:0]        crc_q, crc_d, crc_nxt;
  logic [15:0]        len_q, len_d;
  logic               pre_err_q, pre_err_d;
  logic               ifg_q, ifg_d;
  logic               tx_en_prev_q;
  logic               frame_stb_q, frame_stb_d;
  logic [15:0]        frame_len_q, frame_len_d;
  logic [ERR_W-1:0]   frame_err_q, frame_err_d;
  logic [15:0]        good_cnt_q, good_cnt_d;
  logic [15:0]        bad_cnt_q, bad_cnt_d;

  logic               in_frame;
  logic               start;
  logic [7:0]         pre_cnt_base;
  logic               pre_err_base;
  logic [ERR_W-1:0]   err_v;

  crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (txd),
    .crc_o  (crc_nxt)
  );

  assign in_frame = (state_q == ST_PRE) || (state_q == ST_BODY);

  // A frame only starts on a rising tx_en, so a reset released mid-frame
  // ignores the remainder of that frame.
  assign start = !in_frame && tx_en && !tx_en_prev_q;

  // The first byte of a frame is parsed in the same cycle it starts, so the
  // preamble bookkeeping is evaluated against cleared values on start.
  assign pre_cnt_base = start ? 8'd0 : pre_cnt_q;
  assign pre_err_base = start ? 1'b0 : pre_err_q;

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    pre_err_d   = pre_err_q;
    ifg_d       = ifg_q;
    crc_d       = crc_q;
    len_d       = len_q;
    gap_cnt_d   = gap_cnt_q;
    frame_stb_d = 1'b0;
    frame_len_d = frame_len_q;
    frame_err_d = frame_err_q;
    err_v       = '0;

    if (!tx_en) begin
      gap_cnt_d = sat_inc8(gap_cnt_q);
    end else if (start || in_frame) begin
      gap_cnt_d = 8'd0;
    end

    if (start) begin
      ifg_d = (gap_cnt_q < MIN_IFG_C);
    end

    if (start || (state_q == ST_PRE && tx_en)) begin
      state_d   = ST_PRE;
      pre_cnt_d = pre_cnt_base;
      pre_err_d = pre_err_base;
      if (txd == PRE_BYTE) begin
        pre_cnt_d = sat_inc8(pre_cnt_base);
      end else if (txd == SFD) begin
        state_d   = ST_BODY;
        pre_err_d = pre_err_base | (pre_cnt_base != PRE_LEN_C);
        crc_d     = CRC_INIT;
        len_d     = 16'd0;
      end else begin
        pre_err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_GAP: begin
          if (gap_cnt_d >= MIN_IFG_C) state_d = ST_IDLE;
        end
        ST_PRE: begin
          err_v[ERR_ABORT] = 1'b1;
          err_v[ERR_PRE]   = pre_err_q;
          err_v[ERR_IFG]   = ifg_q;
          state_d          = ST_GAP;
          frame_stb_d      = 1'b1;
          frame_len_d      = 16'd0;
          frame_err_d      = err_v;
        end
        ST_BODY: begin
          if (tx_en) begin
            crc_d = crc_nxt;
            len_d = sat_inc16(len_q);
          end else begin
            err_v[ERR_CRC]   = (crc_q != CRC_RESIDUE);
            err_v[ERR_PRE]   = pre_err_q;
            err_v[ERR_RUNT]  = (len_q < MIN_LEN_C);
            err_v[ERR_GIANT] = (len_q > MAX_LEN_C);
            err_v[ERR_IFG]   = ifg_q;
            state_d          = ST_GAP;
            frame_stb_d      = 1'b1;
            frame_len_d      = len_q;
            frame_err_d      = err_v;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (clr) begin
      good_cnt_d = 16'd0;
      bad_cnt_d  = 16'd0;
    end else if (frame_stb_q) begin
      if (frame_err_q == '0) good_cnt_d = sat_inc16(good_cnt_q);
      else                   bad_cnt_d  = sat_inc16(bad_cnt_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pre_cnt_q    <= 8'd0;
      gap_cnt_q    <= 8'hFF;
      crc_q        <= CRC_INIT;
      len_q        <= 16'd0;
      pre_err_q    <= 1'b0;
      ifg_q        <= 1'b0;
      tx_en_prev_q <= 1'b1;
      frame_stb_q  <= 1'b0;
      frame_len_q  <= 16'd0;
      frame_err_q  <= '0;
      good_cnt_q   <= 16'd0;
      bad_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      crc_q        <= crc_d;
      len_q        <= len_d;
      pre_err_q    <= pre_err_d;
      ifg_q        <= ifg_d;
      tx_en_prev_q <= tx_en;
      frame_stb_q  <= frame_stb_d;
      frame_len_q  <= frame_len_d;
      frame_err_q  <= frame_err_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
    end
  end

  assign frame_stb = frame_stb_q;
  assign frame_len = frame_len_q;
  assign frame_err = frame_err_q;
  assign good_cnt  = good_cnt_q;
  assign bad_cnt   = bad_cnt_q;
  assign busy      = in_frame;

endmodule

// File: tb/tb_gmii_tx_checker.sv
// Directed bench for gmii_tx_checker: frames are built with a bench-side CRC,
// expected reports are queued at send time and compared on each strobe.
module tb_gmii_tx_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  txd = 8'h00;
  logic        tx_en = 1'b0;
  logic        clr = 1'b0;
  logic        frame_stb;
  logic [15:0] frame_len;
  logic [5:0]  frame_err;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
  logic        busy;

  gmii_tx_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .txd       (txd),
    .tx_en     (tx_en),
    .clr       (clr),
    .frame_stb (frame_stb),
    .frame_len (frame_len),
    .frame_err (frame_err),
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt),
    .busy      (busy)
  );

  always #4 clk = ~clk;

  typedef struct {
    string tag;
    int    len;
    int    err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] body_q[$];
  int         errors = 0;
  int         checks = 0;
  int         unexp_stb = 0;
  int         good_exp = 0;
  int         bad_exp = 0;
  logic       prev_stb = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe pops the oldest expected report.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb = 1'b0;
    end else begin
      if (frame_stb) begin
        check("stb_one_cycle", {31'b0, prev_stb}, 32'd0);
        if (exp_q.size() == 0) begin
          unexp_stb++;
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.tag, "_len"}, {16'b0, frame_len}, e.len);
          check({e.tag, "_err"}, {26'b0, frame_err}, e.err);
        end
      end
      prev_stb = frame_stb;
    end
  end

  task automatic expect_frame(input string tag, input int len, input int err);
    exp_t e;
    e.tag = tag;
    e.len = len;
    e.err = err;
    exp_q.push_back(e);
    if (err == 0) good_exp++;
    else          bad_exp++;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    tx_en = 1'b1;
    txd   = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tx_en = 1'b0;
      txd   = 8'h00;
    end
  endtask

  // Bit-serial reference CRC over body_q; FCS is appended low byte first.
  task automatic append_fcs();
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (body_q[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ body_q[k][i];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    c = ~c;
    body_q.push_back(c[7:0]);
    body_q.push_back(c[15:8]);
    body_q.push_back(c[23:16]);
    body_q.push_back(c[31:24]);
  endtask

  task automatic build_zero_frame(input int total_len);
    body_q.delete();
    for (int i = 0; i < total_len - 4; i++) body_q.push_back(8'h00);
    append_fcs();
  endtask

  // n_body < 0 sends the whole body.
  task automatic send_frame(input int pre_n, input int n_body);
    int n;
    n = (n_body < 0) ? body_q.size() : n_body;
    for (int i = 0; i < pre_n; i++) drive_byte(8'h55);
    drive_byte(8'hD5);
    for (int i = 0; i < n; i++) drive_byte(body_q[i]);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
    check({tag, "_drain"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    check({tag, "_good"}, {16'b0, good_cnt}, good_exp);
    check({tag, "_bad"},  {16'b0, bad_cnt},  bad_exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_stb",  {31'b0, frame_stb}, 32'd0);
    check("rst_len",  {16'b0, frame_len}, 32'd0);
    check("rst_err",  {26'b0, frame_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check_counts("rst");

    // Good minimum-length frame.
    build_zero_frame(64);
    expect_frame("good64", 64, 0);
    send_frame(7, 1);
    @(negedge clk);
    check("busy_body", {31'b0, busy}, 32'd1);
    for (int i = 1; i < body_q.size(); i++) drive_byte(body_q[i]);
    idle(12);
    wait_drain("good64");
    check_counts("good64");

    // Standard check value with its known FCS: CRC good, runt.
    body_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
    expect_frame("check_val", 13, 6'h04);
    send_frame(7, -1);
    idle(12);
    wait_drain("check_val");
    check_counts("check_val");
    check("hold_len", {16'b0, frame_len}, 32'd13);
    check("hold_err", {26'b0, frame_err}, 32'h04);

    // Single payload bit flipped.
    build_zero_frame(64);
    body_q[10] = body_q[10] ^ 8'h01;
    expect_frame("crc_bad", 64, 6'h01);
    send_frame(7, -1);
    idle(12);

    // Short preamble, then a frame only five idle cycles later.
    build_zero_frame(64);
    expect_frame("short_pre", 64, 6'h02);
    send_frame(6, -1);
    idle(5);
    expect_frame("close_ifg", 64, 6'h10);
    send_frame(7, -1);
    idle(12);
    wait_drain("ifg");

    // Length boundaries.
    build_zero_frame(63);
    expect_frame("len63", 63, 6'h04);
    send_frame(7, -1);
    idle(12);
    build_zero_frame(1518);
    expect_frame("len1518", 1518, 0);
    send_frame(7, -1);
    idle(12);
    build_zero_frame(1519);
    expect_frame("len1519", 1519, 6'h08);
    send_frame(7, -1);
    idle(12);

    // Abort after three preamble bytes.
    expect_frame("abort", 0, 6'h20);
    for (int i = 0; i < 3; i++) drive_byte(8'h55);
    idle(12);
    wait_drain("abort");
    check_counts("pre_clr");

    // Clear coincident with the counter increment of a good frame.
    build_zero_frame(64);
    expect_frame("clr_frame", 64, 0);
    send_frame(7, -1);
    idle(1);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    good_exp = 0;
    bad_exp  = 0;
    idle(10);
    wait_drain("clr");
    check_counts("clr");

    expect_frame("pre_rst", 64, 0);
    send_frame(7, -1);
    idle(12);
    wait_drain("pre_rst");
    check_counts("pre_rst");

    // Reset in the middle of the body; the tail of that frame is ignored.
    send_frame(7, 20);
    @(posedge clk);
    #1 rst_n = 1'b0;
    good_exp = 0;
    bad_exp  = 0;
    @(negedge clk);
    check("in_rst_busy", {31'b0, busy}, 32'd0);
    check_counts("in_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) drive_byte(8'hA5);
    idle(12);
    check_counts("post_rst");
    expect_frame("after_rst", 64, 0);
    send_frame(7, -1);
    idle(12);
    wait_drain("after_rst");
    check_counts("after_rst");

    check("unexpected_strobes", unexp_stb, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
